// File: rtl/fence_sequencer_if.sv
// Handshake bundle between the execute stage / LSU and the fence sequencer.
// The slave modport is the sequencer's view; the master modport is the requester's view.
interface fence_sequencer_if #(
  parameter int NUM_FLUSH_CH = 2
);
  logic                    req_valid_i;
  logic                    req_ready_o;
  logic                    req_fence_i_i;
  logic [3:0]              req_pred_i;
  logic [3:0]              req_succ_i;
  logic                    st_issue_i;
  logic                    st_done_i;
  logic                    st_full_o;
  logic                    mem_barrier_o;
  logic                    mem_barrier_ack_i;
  logic [NUM_FLUSH_CH-1:0] flush_req_o;
  logic [NUM_FLUSH_CH-1:0] flush_ack_i;
  logic                    sync_req_o;
  logic                    sync_ack_i;
  logic                    done_o;
  logic                    err_o;

  modport slave (
    input  req_valid_i, req_fence_i_i, req_pred_i, req_succ_i,
    input  st_issue_i, st_done_i,
    input  mem_barrier_ack_i, flush_ack_i, sync_ack_i,
    output req_ready_o, st_full_o, mem_barrier_o, flush_req_o, sync_req_o,
    output done_o, err_o
  );

  modport master (
    output req_valid_i, req_fence_i_i, req_pred_i, req_succ_i,
    output st_issue_i, st_done_i,
    output mem_barrier_ack_i, flush_ack_i, sync_ack_i,
    input  req_ready_o, st_full_o, mem_barrier_o, flush_req_o, sync_req_o,
    input  done_o, err_o
  );
endinterface

// File: rtl/fence_sequencer.sv
// FENCE / FENCE.I sequencer: store drain, memory barrier, multi-channel flush and
// multi-core sync in strict order, each wait bounded by a shared timeout.
module fence_sequencer #(
  parameter int NUM_CORES      = 1,
  parameter int NUM_FLUSH_CH   = 2,
  parameter int MAX_PEND_ST    = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic              clk_i,
  input logic              rst_i,
  fence_sequencer_if.slave bus
);
  localparam int PW = $clog2(MAX_PEND_ST + 1);
  localparam int TW = 16;
  localparam logic [PW-1:0]           PEND_MAX = PW'(MAX_PEND_ST);
  localparam logic [TW-1:0]           TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam bit                      TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam bit                      MULTI    = (NUM_CORES > 1);
  localparam logic [NUM_FLUSH_CH-1:0] ALL_CH   = '1;
  // ch0 is the I-cache; a plain FENCE only touches the data-side levels
  localparam logic [NUM_FLUSH_CH-1:0] DATA_CH  = ALL_CH << 1;

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_BARRIER, S_FLUSH, S_SYNC, S_DONE
  } state_t;

  state_t                  r_state;
  logic [PW-1:0]           r_pend;
  logic [TW-1:0]           r_tmo;
  logic [NUM_FLUSH_CH-1:0] r_ack;
  logic                    r_err;
  logic                    r_fence_i;
  logic [3:0]              r_pred;
  logic [3:0]              r_succ;
  logic                    r_ready;
  logic                    r_bar;
  logic [NUM_FLUSH_CH-1:0] r_flush;
  logic                    r_sync;
  logic                    r_done;

  logic                    w_accept;
  logic                    w_st_full;
  logic                    w_drain;
  logic                    w_bar;
  logic                    w_sync;
  logic [NUM_FLUSH_CH-1:0] w_fmask;
  logic [NUM_FLUSH_CH-1:0] w_flush_hit;
  logic                    w_flush_cov;
  logic                    w_tmo_lim;
  logic                    w_tmo_hit;
  logic                    w_wait;
  logic                    w_exit;
  state_t                  w_target;
  state_t                  w_after_drain;
  state_t                  w_after_bar;
  state_t                  w_after_flush;
  state_t                  w_nxt;

  assign w_accept  = bus.req_valid_i & r_ready;
  assign w_st_full = (r_pend == PEND_MAX);

  // Decode always works from the latched request, never the live bus
  assign w_drain = r_pred[0] | r_fence_i;
  assign w_bar   = r_fence_i
                 | ((|r_pred[1:0]) & (|r_succ[1:0]))
                 | (|r_pred[3:2]) | (|r_succ[3:2]);
  assign w_fmask = r_fence_i ? ALL_CH
                 : ((r_pred[2] | r_succ[3]) ? DATA_CH : '0);
  assign w_sync  = MULTI & w_bar;

  assign w_flush_hit = bus.flush_ack_i & r_flush;
  assign w_flush_cov = ((r_ack | w_flush_hit) & w_fmask) == w_fmask;
  assign w_tmo_lim   = TMO_EN && (r_tmo == TMO_LAST);

  assign w_after_flush = w_sync ? S_SYNC : S_DONE;
  assign w_after_bar   = (|w_fmask) ? S_FLUSH : w_after_flush;
  assign w_after_drain = w_bar ? S_BARRIER : w_after_bar;

  always_comb begin
    w_wait   = 1'b1;
    w_exit   = 1'b0;
    w_target = S_DONE;
    case (r_state)
      S_DRAIN:   begin w_exit = !w_drain || (r_pend == '0); w_target = w_after_drain; end
      S_BARRIER: begin w_exit = bus.mem_barrier_ack_i;     w_target = w_after_bar;   end
      S_FLUSH:   begin w_exit = w_flush_cov;               w_target = w_after_flush; end
      S_SYNC:    begin w_exit = bus.sync_ack_i;            w_target = S_DONE;        end
      default:   w_wait = 1'b0;
    endcase
  end

  // An ack landing on the timeout cycle wins over the timeout
  always_comb begin
    w_tmo_hit = w_wait && !w_exit && w_tmo_lim;
    w_nxt     = r_state;
    if (r_state == S_IDLE) begin
      if (w_accept) w_nxt = S_DRAIN;
    end else if (r_state == S_DONE) begin
      w_nxt = S_IDLE;
    end else if (w_exit) begin
      w_nxt = w_target;
    end else if (w_tmo_hit) begin
      w_nxt = S_DONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_pend    <= '0;
      r_tmo     <= '0;
      r_ack     <= '0;
      r_err     <= 1'b0;
      r_fence_i <= 1'b0;
      r_pred    <= '0;
      r_succ    <= '0;
      r_ready   <= 1'b1;
      r_bar     <= 1'b0;
      r_flush   <= '0;
      r_sync    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_ready <= (w_nxt == S_IDLE);
      r_bar   <= (w_nxt == S_BARRIER);
      r_sync  <= (w_nxt == S_SYNC);
      r_done  <= (w_nxt == S_DONE);

      // Each requested channel drops its request the cycle after its own ack
      if (w_nxt != S_FLUSH)        r_flush <= '0;
      else if (r_state == S_FLUSH) r_flush <= r_flush & ~bus.flush_ack_i;
      else                         r_flush <= w_fmask;

      if ((w_nxt != r_state) || !w_wait) r_tmo <= '0;
      else                               r_tmo <= r_tmo + 1'b1;

      if (w_accept) begin
        r_fence_i <= bus.req_fence_i_i;
        r_pred    <= bus.req_pred_i;
        r_succ    <= bus.req_succ_i;
      end

      if (r_state == S_DONE) begin
        r_ack <= '0;
        r_err <= 1'b0;
      end else begin
        if (r_state == S_FLUSH) r_ack <= r_ack | w_flush_hit;
        if (w_tmo_hit)          r_err <= 1'b1;
      end

      // Store tracking runs in every state; issue+done together nets to zero
      if (bus.st_issue_i && !bus.st_done_i && !w_st_full)
        r_pend <= r_pend + 1'b1;
      else if (bus.st_done_i && !bus.st_issue_i && (r_pend != '0))
        r_pend <= r_pend - 1'b1;
    end
  end

  assign bus.req_ready_o   = r_ready;
  assign bus.st_full_o     = w_st_full;
  assign bus.mem_barrier_o = r_bar;
  assign bus.flush_req_o   = r_flush;
  assign bus.sync_req_o    = r_sync;
  assign bus.done_o        = r_done;
  assign bus.err_o         = r_done & r_err;
endmodule

// File: tb/tb_fence_sequencer.sv
// Bench for fence_sequencer: directed corner sequences, a store-counter vector table,
// and random traffic compared every cycle against a phase-list reference model.
module tb_fence_sequencer;
  localparam int NC  = 2;
  localparam int NF  = 3;
  localparam int MP  = 8;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fence_sequencer_if #(.NUM_FLUSH_CH(NF)) bus();

  fence_sequencer #(
    .NUM_CORES(NC), .NUM_FLUSH_CH(NF), .MAX_PEND_ST(MP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_prn = 0;
  int n_done = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a fence becomes an ordered list of phases at accept time
  // (1=drain 2=barrier 3=flush 4=sync 5=done); the head of the list is the active phase.
  int          plan[$];
  int          m_pend = 0;
  int          m_cyc = 0;
  bit          m_drain, m_err;
  logic [NF-1:0] m_fmask = '0;
  logic [NF-1:0] m_ackd = '0;

  always @(posedge clk) begin : model
    int cur;
    bit ex, bar, sync;
    logic [NF-1:0] req;
    if (rst) begin
      plan.delete();
      m_pend = 0; m_cyc = 0; m_ackd = '0; m_err = 1'b0;
    end else begin
      if (plan.size() == 0) begin
        if (bus.req_valid_i) begin
          m_drain = bus.req_pred_i[0] || bus.req_fence_i_i;
          bar = bus.req_fence_i_i
             || (bus.req_pred_i[1:0] != 0 && bus.req_succ_i[1:0] != 0)
             || bus.req_pred_i[3:2] != 0 || bus.req_succ_i[3:2] != 0;
          m_fmask = '0;
          for (int ch = 0; ch < NF; ch++)
            if (bus.req_fence_i_i || (ch > 0 && (bus.req_pred_i[2] || bus.req_succ_i[3])))
              m_fmask[ch] = 1'b1;
          sync = (NC > 1) && bar;
          plan.push_back(1);
          if (bar) plan.push_back(2);
          if (m_fmask != 0) plan.push_back(3);
          if (sync) plan.push_back(4);
          plan.push_back(5);
          m_cyc = 0;
        end
      end else begin
        cur = plan[0];
        req = (cur == 3) ? (m_fmask & ~m_ackd) : '0;
        case (cur)
          1: ex = !m_drain || m_pend == 0;
          2: ex = bus.mem_barrier_ack_i;
          3: ex = ((m_ackd | (bus.flush_ack_i & req)) & m_fmask) == m_fmask;
          4: ex = bus.sync_ack_i;
          default: ex = 1'b1;
        endcase
        if (cur == 3) m_ackd = m_ackd | (bus.flush_ack_i & req);
        if (ex) begin
          void'(plan.pop_front());
          m_cyc = 0;
          if (cur == 5) begin m_ackd = '0; m_err = 1'b0; end
        end else if (TMO != 0 && m_cyc == TMO - 1) begin
          m_err = 1'b1;
          plan.delete();
          plan.push_back(5);
          m_cyc = 0;
        end else begin
          m_cyc++;
        end
      end
      if (bus.st_issue_i && !bus.st_done_i && m_pend < MP) m_pend++;
      else if (bus.st_done_i && !bus.st_issue_i && m_pend > 0) m_pend--;
    end
  end

  always @(negedge clk) begin : compare
    int cur;
    logic [8:0] e, a;
    if (chk_en) begin
      cur = (plan.size() != 0) ? plan[0] : 0;
      e = {plan.size() == 0, cur == 2, (cur == 3) ? (m_fmask & ~m_ackd) : {NF{1'b0}},
           cur == 4, cur == 5, cur == 5 && m_err, m_pend == MP};
      a = {bus.req_ready_o, bus.mem_barrier_o, bus.flush_req_o, bus.sync_req_o,
           bus.done_o, bus.err_o, bus.st_full_o};
      if (bus.done_o === 1'b1) n_done++;
      n_chk++;
      if (a !== e) begin
        n_fail++;
        if (n_prn < 20)
          $display("FAIL model t=%0t: got rdy/bar/fl/sy/dn/er/full=%b, expected %b", $time, a, e);
        n_prn++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.req_valid_i = 1'b0; bus.req_fence_i_i = 1'b0;
    bus.req_pred_i = 4'h0;  bus.req_succ_i = 4'h0;
    bus.st_issue_i = 1'b0;  bus.st_done_i = 1'b0;
    bus.mem_barrier_ack_i = 1'b0; bus.flush_ack_i = '0; bus.sync_ack_i = 1'b0;
  endtask

  task automatic fence(input logic fi, input logic [3:0] pred, input logic [3:0] succ);
    bus.req_valid_i = 1'b1; bus.req_fence_i_i = fi;
    bus.req_pred_i = pred;  bus.req_succ_i = succ;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (bus.req_ready_o !== 1'b1 && k < 64) begin cyc(); k++; end
    chk("wait_idle", bus.req_ready_o, 1);
  endtask

  typedef struct packed { logic iss; logic dn; logic full; } vec_t;
  vec_t tv[20];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: no finish by time %0t, expected finish earlier", $time);
    $fatal(1);
  end

  initial begin
    int ns;
    for (int i = 0; i < 10; i++) tv[i] = '{iss: 1'b1, dn: 1'b0, full: (i >= 7)};
    tv[10] = '{iss: 1'b1, dn: 1'b1, full: 1'b1};
    for (int i = 11; i < 19; i++) tv[i] = '{iss: 1'b0, dn: 1'b1, full: 1'b0};
    tv[19] = '{iss: 1'b0, dn: 1'b1, full: 1'b0};

    rst = 1'b1;
    clr();
    repeat (2) cyc();
    chk("rst_ready", bus.req_ready_o, 1);
    chk("rst_outs", {bus.mem_barrier_o, bus.flush_req_o, bus.sync_req_o,
                     bus.done_o, bus.err_o, bus.st_full_o}, 0);
    rst = 1'b0;
    chk_en = 1'b1;
    cyc();

    // nop FENCE: done two cycles after accept
    fence(1'b0, 4'h0, 4'h0);
    cyc(); clr();
    chk("t1_c1_done", bus.done_o, 0);
    chk("t1_c1_ready", bus.req_ready_o, 0);
    cyc();
    chk("t1_c2_done", bus.done_o, 1);
    chk("t1_c2_err", bus.err_o, 0);
    cyc();
    chk("t1_c3_ready", bus.req_ready_o, 1);

    // Three stores outstanding, FENCE W->R must hold the barrier until they drain
    bus.st_issue_i = 1'b1;
    cyc(); cyc(); cyc();
    bus.st_issue_i = 1'b0;
    fence(1'b0, 4'b0001, 4'b0010);
    cyc();
    for (int c = 1; c <= 14; c++) begin
      clr();
      bus.st_done_i = (c == 5 || c == 6 || c == 9);
      bus.mem_barrier_ack_i = (c == 12);
      bus.sync_ack_i = (c == 13);
      chk($sformatf("t2_bar_c%0d", c), bus.mem_barrier_o, (c == 11 || c == 12));
      chk($sformatf("t2_done_c%0d", c), bus.done_o, (c == 14));
      if (c == 14) chk("t2_err", bus.err_o, 0);
      cyc();
    end
    wait_idle();

    // FENCE.I with out-of-order flush acks
    fence(1'b1, 4'h0, 4'h0);
    cyc();
    for (int c = 1; c <= 9; c++) begin
      logic [NF-1:0] ef;
      clr();
      bus.mem_barrier_ack_i = (c == 2);
      bus.flush_ack_i = (c == 4) ? 3'b100 : ((c == 7) ? 3'b011 : 3'b000);
      bus.sync_ack_i = (c == 8);
      ef = (c == 3 || c == 4) ? 3'b111 : ((c >= 5 && c <= 7) ? 3'b011 : 3'b000);
      chk($sformatf("t3_flush_c%0d", c), bus.flush_req_o, ef);
      chk($sformatf("t3_sync_c%0d", c), bus.sync_req_o, (c == 8));
      chk($sformatf("t3_done_c%0d", c), bus.done_o, (c == 9));
      cyc();
    end
    wait_idle();

    // Sync never acknowledged: times out after exactly TMO cycles
    fence(1'b0, 4'b0100, 4'b1000);
    cyc();
    ns = 0;
    for (int c = 1; c <= 21; c++) begin
      clr();
      bus.mem_barrier_ack_i = (c == 2);
      bus.flush_ack_i = (c == 3) ? 3'b110 : 3'b000;
      if (bus.sync_req_o === 1'b1) ns++;
      chk($sformatf("t4_sync_c%0d", c), bus.sync_req_o, (c >= 4 && c <= 19));
      chk($sformatf("t4_done_c%0d", c), bus.done_o, (c == 20));
      chk($sformatf("t4_err_c%0d", c), bus.err_o, (c == 20));
      cyc();
    end
    chk("t4_sync_len", ns, TMO);
    wait_idle();

    // Pending-store counter: saturation, simultaneous issue/done, floor at zero
    for (int i = 0; i < 20; i++) begin
      clr();
      bus.st_issue_i = tv[i].iss;
      bus.st_done_i = tv[i].dn;
      cyc();
      chk($sformatf("t5_full_%0d", i), bus.st_full_o, tv[i].full);
    end
    clr();
    fence(1'b0, 4'b0001, 4'b0000);
    cyc(); clr();
    cyc();
    chk("t5_drain_zero_done", bus.done_o, 1);
    chk("t5_drain_zero_err", bus.err_o, 0);
    wait_idle();

    // Reset while flushing aborts without a done pulse
    fence(1'b1, 4'h0, 4'h0);
    cyc(); clr();
    cyc();
    bus.mem_barrier_ack_i = 1'b1;
    cyc(); clr();
    chk("t6_in_flush", bus.flush_req_o, 3'b111);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6_flush", bus.flush_req_o, 0);
    chk("t6_ready", bus.req_ready_o, 1);
    chk("t6_bar_sync", {bus.mem_barrier_o, bus.sync_req_o}, 0);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("t6_nodone_%0d", c), bus.done_o, 0);
      cyc();
    end

    // Random traffic against the model
    n_done = 0;
    for (int i = 0; i < 3000; i++) begin
      bus.req_valid_i = ($urandom_range(0, 3) == 0);
      bus.req_fence_i_i = ($urandom_range(0, 4) == 0);
      bus.req_pred_i = 4'($urandom);
      bus.req_succ_i = 4'($urandom);
      bus.st_issue_i = ($urandom_range(0, 2) == 0);
      bus.st_done_i = ($urandom_range(0, 2) == 0);
      bus.mem_barrier_ack_i = ($urandom_range(0, 5) == 0);
      for (int ch = 0; ch < NF; ch++) bus.flush_ack_i[ch] = ($urandom_range(0, 3) == 0);
      bus.sync_ack_i = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 499) == 0);
      cyc();
    end
    rst = 1'b0;
    clr();
    cyc();
    chk("rand_activity", (n_done > 20), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
